// File: rtl/me_job_sequencer.sv
// me_job_sequencer: drives NUM_BLK me_double req/ack handshakes per job and queues results in a show-ahead FIFO.
// Optional watchdog enabled by defining ME_WDOG_EN (aborts a stalled handshake after WDOG_CYC cycles).
module me_job_sequencer #(
  parameter int NUM_BLK    = 16,
  parameter int BLK_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int WDOG_CYC   = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [BLK_W-1:0] blk_idx,
  output logic             me_req,
  input  logic             me_ack,
  input  logic [15:0]      me_min_sad,
  input  logic [9:0]       me_min_mvec,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_sad,
  output logic [9:0]       res_mvec,
  output logic [BLK_W-1:0] res_idx
`ifdef ME_WDOG_EN
  ,
  output logic             wdog_err
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_NEXT, S_FIN} state_t;

  typedef struct packed {
    logic [15:0]      sad;
    logic [9:0]       mvec;
    logic [BLK_W-1:0] idx;
  } res_t;

  localparam int               PW       = $clog2(FIFO_DEPTH);
  localparam logic [BLK_W-1:0] LAST     = BLK_W'(NUM_BLK - 1);
  localparam logic [PW:0]      FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  generate
    if (NUM_BLK < 1 || (2 ** BLK_W) < NUM_BLK || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WDOG_CYC < 1) begin : g_bad_cfg
      $error("me_job_sequencer: illegal parameter combination");
    end
  endgenerate

  state_t          state, state_nxt;
  res_t            mem [FIFO_DEPTH];
  res_t            head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            full, pop, push, wdog_hit, abort;

  assign full      = (count == FULL_CNT);
  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push      = (state == S_REQ) && me_ack && (!full || pop);
  assign abort     = wdog_hit && (((state == S_REQ) && !push) || ((state == S_REL) && me_ack));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_REQ;
      S_REQ: begin
        if (push)       state_nxt = S_REL;
        else if (abort) state_nxt = S_FIN;
      end
      S_REL: begin
        if (!me_ack)    state_nxt = S_NEXT;
        else if (abort) state_nxt = S_FIN;
      end
      S_NEXT:  state_nxt = (blk_idx == LAST) ? S_FIN : S_REQ;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    me_req = (state == S_REQ);
    busy   = (state != S_IDLE);
    done   = (state == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                              blk_idx <= '0;
    else if (state == S_IDLE && start)       blk_idx <= '0;
    else if (state == S_NEXT && blk_idx != LAST) blk_idx <= blk_idx + BLK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{sad: me_min_sad, mvec: me_min_mvec, idx: blk_idx};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head     = mem[rd_ptr];
  assign res_sad  = head.sad;
  assign res_mvec = head.mvec;
  assign res_idx  = head.idx;

`ifdef ME_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);

  logic [WD_W-1:0] wdog_cnt;
  logic            in_wait, in_wait_nxt;

  assign in_wait     = (state == S_REQ) || (state == S_REL);
  assign in_wait_nxt = (state_nxt == S_REQ) || (state_nxt == S_REL);
  assign wdog_hit    = in_wait && (wdog_cnt == WD_W'(WDOG_CYC - 1));

  // restarts on every entry to REQ or REL, so each handshake phase gets the full budget
  always_ff @(posedge clk) begin
    if (!rst_n)                                 wdog_cnt <= '0;
    else if (in_wait_nxt && state_nxt != state) wdog_cnt <= '0;
    else if (in_wait)                           wdog_cnt <= wdog_cnt + WD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                        wdog_err <= 1'b0;
    else if (state == S_IDLE && start) wdog_err <= 1'b0;
    else if (abort)                    wdog_err <= 1'b1;
  end
`else
  assign wdog_hit = 1'b0;
`endif

endmodule

// File: tb/tb_me_job_sequencer.sv
// Bench for me_job_sequencer: bus-functional me_double responder, consumer, and expected-result model.
module tb_me_job_sequencer;
  localparam int NUM_BLK = 4, BLK_W = 2, FIFO_DEPTH = 2, WDOG_CYC = 16;
`ifdef ME_WDOG_EN
  localparam int T1_DLY = 10;
`else
  localparam int T1_DLY = 20;
`endif

  logic clk, rst_n, start, busy, done, me_req, me_ack, res_valid, res_ready;
  logic [BLK_W-1:0] blk_idx, res_idx;
  logic [15:0] me_min_sad, res_sad;
  logic [9:0]  me_min_mvec, res_mvec;
`ifdef ME_WDOG_EN
  logic wdog_err;
`endif

  me_job_sequencer #(.NUM_BLK(NUM_BLK), .BLK_W(BLK_W), .FIFO_DEPTH(FIFO_DEPTH), .WDOG_CYC(WDOG_CYC)) dut (
`ifdef ME_WDOG_EN
    .wdog_err(wdog_err),
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .blk_idx(blk_idx),
    .me_req(me_req), .me_ack(me_ack), .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
    .res_valid(res_valid), .res_ready(res_ready), .res_sad(res_sad), .res_mvec(res_mvec),
    .res_idx(res_idx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // responder: 0 = random ack delay + random data, 1 = fixed delay + sad=100+i, 2 = never ack
  int resp_mode = 1, fix_dly = 2, rnd_dly = 0, wcnt = 0;
  logic [15:0] mdl_sad  [NUM_BLK];
  logic [9:0]  mdl_mvec [NUM_BLK];

  initial begin
    me_ack = 1'b0; me_min_sad = '0; me_min_mvec = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        me_ack = 1'b0; wcnt = 0;
      end else if (!me_ack) begin
        if (me_req && resp_mode != 2) begin
          if (wcnt >= ((resp_mode == 0) ? rnd_dly : fix_dly)) begin
            me_ack = 1'b1;
            if (resp_mode == 1) begin
              me_min_sad  = 16'(100 + int'(blk_idx));
              me_min_mvec = {5'(blk_idx), 5'd3};
            end else begin
              me_min_sad  = 16'($urandom);
              me_min_mvec = 10'($urandom);
            end
            mdl_sad[blk_idx]  = me_min_sad;
            mdl_mvec[blk_idx] = me_min_mvec;
            wcnt = 0;
            rnd_dly = $urandom_range(0, 6);
          end else wcnt++;
        end else wcnt = 0;
      end else if (!me_req) me_ack = 1'b0;
    end
  end

  logic [15:0]      obs_sad [$];
  logic [9:0]       obs_mvec[$];
  logic [BLK_W-1:0] obs_idx [$];
  int done_cnt, req_rises, rdy_cycles;
  bit timed_out;

  // consumer: ready mode 0 = always, 1 = random 75%, 2 = only while ack is present (plus drain after done)
  task automatic run_collect(input int max_cyc, input int rdy_mode, input int s_a, input int s_b,
                             input int s_c, input bit sod);
    int cyc; bit seen_done; bit prev_req;
    obs_sad.delete(); obs_mvec.delete(); obs_idx.delete();
    done_cnt = 0; req_rises = 0; rdy_cycles = 0; timed_out = 0;
    cyc = 0; seen_done = 0; prev_req = me_req;
    forever begin
      @(negedge clk);
      start = (cyc == s_a) || (cyc == s_b) || (cyc == s_c) || (sod && done);
      case (rdy_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = ($urandom_range(0, 3) != 0);
        default: res_ready = seen_done || (me_req && me_ack && int'(blk_idx) >= FIFO_DEPTH);
      endcase
      if (res_ready && !seen_done) rdy_cycles++;
      if (res_valid && res_ready) begin
        obs_sad.push_back(res_sad); obs_mvec.push_back(res_mvec); obs_idx.push_back(res_idx);
      end
      if (done) begin done_cnt++; seen_done = 1; end
      if (me_req && !prev_req) req_rises++;
      prev_req = me_req;
      cyc++;
      if (seen_done && !res_valid && !busy) break;
      if (cyc >= max_cyc) begin timed_out = 1; break; end
    end
    start = 1'b0; res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (me_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got req=%b busy=%b done=%b want 0 0 0", me_req, busy, done); end
    checks++; if (blk_idx !== '0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL reset_fifo: got idx=%0d valid=%b want 0 0", blk_idx, res_valid); end
    checks++; if (res_sad !== '0 || res_mvec !== '0 || res_idx !== '0) begin
      errors++; $display("FAIL reset_data: got sad=%0d mvec=%0d idx=%0d want 0", res_sad, res_mvec, res_idx); end
`ifdef ME_WDOG_EN
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog: got %b want 0", wdog_err); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    resp_mode = 1; fix_dly = T1_DLY;
    run_collect(600, 0, 0, -1, -1, 0);
    checks++; if (timed_out || obs_idx.size() != NUM_BLK) begin
      errors++; $display("FAIL basic_count: got %0d results (timeout=%b) want %0d", obs_idx.size(), timed_out, NUM_BLK); end
    for (int k = 0; k < NUM_BLK && k < obs_idx.size(); k++) begin
      checks++;
      if (obs_idx[k] !== BLK_W'(k) || obs_sad[k] !== 16'(100 + k) || obs_mvec[k] !== {5'(k), 5'd3}) begin
        errors++; $display("FAIL basic_res%0d: got idx=%0d sad=%0d mvec=%h want idx=%0d sad=%0d mvec=%h",
                           k, obs_idx[k], obs_sad[k], obs_mvec[k], k, 100 + k, {5'(k), 5'd3}); end
    end
    checks++; if (done_cnt != 1 || req_rises != NUM_BLK) begin
      errors++; $display("FAIL basic_hs: got done=%0d req=%0d want 1 %0d", done_cnt, req_rises, NUM_BLK); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int cyc;
    resp_mode = 1; fix_dly = 2; res_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(me_req && me_ack && blk_idx == BLK_W'(FIFO_DEPTH)) && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (cyc >= 100) begin errors++; $display("FAIL bp_wait: got timeout want stall at idx %0d", FIFO_DEPTH); end
    repeat (3) @(negedge clk);
    checks++; if (me_req !== 1'b1 || me_ack !== 1'b1 || blk_idx !== BLK_W'(FIFO_DEPTH)) begin
      errors++; $display("FAIL bp_hold: got req=%b ack=%b idx=%0d want 1 1 %0d", me_req, me_ack, blk_idx, FIFO_DEPTH); end
    checks++; if (res_valid !== 1'b1 || res_idx !== '0 || res_sad !== 16'd100) begin
      errors++; $display("FAIL bp_head: got valid=%b idx=%0d sad=%0d want 1 0 100", res_valid, res_idx, res_sad); end
    run_collect(300, 0, -1, -1, -1, 0);
    checks++; if (timed_out || obs_idx.size() != NUM_BLK) begin
      errors++; $display("FAIL bp_count: got %0d results want %0d", obs_idx.size(), NUM_BLK); end
    for (int k = 0; k < NUM_BLK && k < obs_idx.size(); k++) begin
      checks++;
      if (obs_idx[k] !== BLK_W'(k) || obs_sad[k] !== 16'(100 + k)) begin
        errors++; $display("FAIL bp_res%0d: got idx=%0d sad=%0d want %0d %0d", k, obs_idx[k], obs_sad[k], k, 100 + k); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    resp_mode = 1; fix_dly = 8;
    run_collect(600, 1, 0, 5, 30, 0);
    checks++; if (timed_out || obs_idx.size() != NUM_BLK || done_cnt != 1) begin
      errors++; $display("FAIL busy_start: got %0d results done=%0d want %0d 1", obs_idx.size(), done_cnt, NUM_BLK); end
    for (int k = 0; k < NUM_BLK && k < obs_idx.size(); k++) begin
      checks++;
      if (obs_idx[k] !== BLK_W'(k) || obs_sad[k] !== 16'(100 + k)) begin
        errors++; $display("FAIL busy_res%0d: got idx=%0d sad=%0d want %0d %0d", k, obs_idx[k], obs_sad[k], k, 100 + k); end
    end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || me_req !== 1'b0) begin
      errors++; $display("FAIL busy_restart: got busy=%b req=%b want 0 0", busy, me_req); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    resp_mode = 1; fix_dly = 3; res_ready = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(me_req && blk_idx == BLK_W'(1)) && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (cyc >= 100 || res_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got cyc=%0d valid=%b want <100 1", cyc, res_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (me_req !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl: got req=%b busy=%b valid=%b done=%b want 0", me_req, busy, res_valid, done); end
    checks++; if (blk_idx !== '0 || res_sad !== '0 || res_idx !== '0) begin
      errors++; $display("FAIL rstmid_data: got idx=%0d sad=%0d ridx=%0d want 0", blk_idx, res_sad, res_idx); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    resp_mode = 0;
    run_collect(600, 1, 0, -1, -1, 0);
    checks++; if (timed_out || obs_idx.size() != NUM_BLK) begin
      errors++; $display("FAIL rstmid_count: got %0d want %0d", obs_idx.size(), NUM_BLK); end
    for (int k = 0; k < NUM_BLK && k < obs_idx.size(); k++) begin
      checks++;
      if (obs_idx[k] !== BLK_W'(k) || obs_sad[k] !== mdl_sad[k] || obs_mvec[k] !== mdl_mvec[k]) begin
        errors++; $display("FAIL rstmid_res%0d: got idx=%0d sad=%0d mvec=%h want %0d %0d %h",
                           k, obs_idx[k], obs_sad[k], obs_mvec[k], k, mdl_sad[k], mdl_mvec[k]); end
    end
  endtask

  task automatic test_full_pushpop();
    resp_mode = 0;
    run_collect(600, 2, 0, -1, -1, 0);
    checks++; if (timed_out || obs_idx.size() != NUM_BLK) begin
      errors++; $display("FAIL full_count: got %0d want %0d", obs_idx.size(), NUM_BLK); end
    for (int k = 0; k < NUM_BLK && k < obs_idx.size(); k++) begin
      checks++;
      if (obs_idx[k] !== BLK_W'(k) || obs_sad[k] !== mdl_sad[k] || obs_mvec[k] !== mdl_mvec[k]) begin
        errors++; $display("FAIL full_res%0d: got idx=%0d sad=%0d want %0d %0d", k, obs_idx[k], obs_sad[k], k, mdl_sad[k]); end
    end
    // one ready cycle per late block means each push landed together with its pop
    checks++; if (rdy_cycles != NUM_BLK - FIFO_DEPTH || done_cnt != 1) begin
      errors++; $display("FAIL full_pushpop: got ready_cycles=%0d done=%0d want %0d 1", rdy_cycles, done_cnt, NUM_BLK - FIFO_DEPTH); end
  endtask

  task automatic test_random();
    for (int j = 0; j < 3; j++) begin
      resp_mode = 0;
      run_collect(800, 1, 0, -1, -1, j == 1);
      checks++; if (timed_out || obs_idx.size() != NUM_BLK || done_cnt != 1) begin
        errors++; $display("FAIL rnd%0d_count: got %0d done=%0d want %0d 1", j, obs_idx.size(), done_cnt, NUM_BLK); end
      for (int k = 0; k < NUM_BLK && k < obs_idx.size(); k++) begin
        checks++;
        if (obs_idx[k] !== BLK_W'(k) || obs_sad[k] !== mdl_sad[k] || obs_mvec[k] !== mdl_mvec[k]) begin
          errors++; $display("FAIL rnd%0d_res%0d: got idx=%0d sad=%0d mvec=%h want %0d %0d %h",
                             j, k, obs_idx[k], obs_sad[k], obs_mvec[k], k, mdl_sad[k], mdl_mvec[k]); end
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle: got busy=%b want 0", j, busy); end
    end
  endtask

`ifdef ME_WDOG_EN
  task automatic test_wdog();
    int cyc, hi, dn;
    resp_mode = 2; res_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; hi = 0; dn = 0;
    while (busy && cyc < 200) begin
      if (me_req) hi++;
      if (done) dn++;
      @(negedge clk); cyc++;
    end
    checks++; if (hi != WDOG_CYC || dn != 1 || cyc >= 200) begin
      errors++; $display("FAIL wdog_abort: got req_cycles=%0d done=%0d want %0d 1", hi, dn, WDOG_CYC); end
    checks++; if (wdog_err !== 1'b1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL wdog_flag: got err=%b valid=%b want 1 0", wdog_err, res_valid); end
    resp_mode = 1; fix_dly = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (wdog_err !== 1'b0 || me_req !== 1'b1) begin
      errors++; $display("FAIL wdog_clear: got err=%b req=%b want 0 1", wdog_err, me_req); end
    run_collect(300, 0, -1, -1, -1, 0);
    checks++; if (timed_out || obs_idx.size() != NUM_BLK || done_cnt != 1) begin
      errors++; $display("FAIL wdog_rerun: got %0d done=%0d want %0d 1", obs_idx.size(), done_cnt, NUM_BLK); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_full_pushpop();
    test_random();
`ifdef ME_WDOG_EN
    test_wdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got no finish by 600000 want earlier finish");
    $fatal(1, "bench time limit");
  end
endmodule
